k2_fetch_sequencer: RTL and testbench

Program sequencer for the K2 8-bit core. Owns the program counter, drives the 4-bit address of the 16-entry combinational instruction ROM, latches the returned byte into an instruction register and issues it to the datapath over a valid/ready handshake. Jumps (J, JC) are resolved locally against the datapath carry flag. Provides run/halt/single-step control for bring-up.

---
 rtl/k2_pkg.sv | 19 +
 rtl/k2_next_pc.sv | 29 ++
 rtl/k2_fetch_sequencer.sv | 130 +++++++++++++
 tb/tb_k2_fetch_sequencer.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/k2_pkg.sv
// Shared types and constants for the K2 program sequencer.
package k2_pkg;

    localparam int K2_ADDR_W  = 4;
    localparam int K2_INSTR_W = 8;
    localparam int K2_CNT_W   = 16;

    localparam logic [3:0] OP_J  = 4'b1010;
    localparam logic [3:0] OP_JC = 4'b1011;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_PAUSE,
        S_HALT
    } seq_state_t;

endpackage

// File: rtl/k2_next_pc.sv
// Next-PC resolution for the K2 sequencer: sequential increment or J/JC target.
module k2_next_pc
    import k2_pkg::*;
#(
    parameter int ADDR_W  = K2_ADDR_W,
    parameter int INSTR_W = K2_INSTR_W
) (
    input  logic [INSTR_W-1:0] ir,
    input  logic [ADDR_W-1:0]  pc,
    input  logic               carry_in,
    output logic [ADDR_W-1:0]  pc_next,
    output logic               jump_taken,
    output logic               self_jump
);

    logic [3:0]        opcode;
    logic [ADDR_W-1:0] target;

    assign opcode = ir[INSTR_W-1 -: 4];
    assign target = ir[ADDR_W-1:0];

    // Increment wraps naturally at 2^ADDR_W.
    always_comb begin
        jump_taken = (opcode == OP_J) || ((opcode == OP_JC) && carry_in);
        pc_next    = jump_taken ? target : pc + ADDR_W'(1);
        self_jump  = jump_taken && (target == pc);
    end

endmodule

// File: rtl/k2_fetch_sequencer.sv
// K2 program sequencer: PC, ROM fetch, instruction register, valid/ready issue
// with local jump resolution and run/halt/single-step control.
module k2_fetch_sequencer
    import k2_pkg::*;
#(
    parameter int ADDR_W  = K2_ADDR_W,
    parameter int INSTR_W = K2_INSTR_W,
    parameter int CNT_W   = K2_CNT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    input  logic               step_mode,
    input  logic               step,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [INSTR_W-1:0] rom_data,
    output logic [INSTR_W-1:0] ir,
    output logic               ir_valid,
    input  logic               ir_ready,
    input  logic               carry_in,
    output logic [ADDR_W-1:0]  pc,
    output logic               halted,
    output logic [CNT_W-1:0]   instr_count
);

    seq_state_t         state_reg;
    seq_state_t         state_next;
    logic [ADDR_W-1:0]  pc_reg;
    logic [ADDR_W-1:0]  pc_next_reg;
    logic [INSTR_W-1:0] ir_reg;
    logic               halted_reg;
    logic [CNT_W-1:0]   instr_count_reg;

    logic [ADDR_W-1:0]  resolved_pc;
    logic               jump_taken;
    logic               self_jump;
    logic               handshake;
    logic               halt_hit;

    k2_next_pc #(
        .ADDR_W  (ADDR_W),
        .INSTR_W (INSTR_W)
    ) u_next_pc (
        .ir         (ir_reg),
        .pc         (pc_reg),
        .carry_in   (carry_in),
        .pc_next    (resolved_pc),
        .jump_taken (jump_taken),
        .self_jump  (self_jump)
    );

    assign handshake = (state_reg == S_ISSUE) && ir_ready;
    assign halt_hit  = jump_taken && self_jump;

    always_comb begin
        state_next = state_reg;
        ir_valid   = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (run) begin
                    state_next = S_FETCH;
                end
            end
            S_FETCH: begin
                state_next = S_ISSUE;
            end
            S_ISSUE: begin
                ir_valid = 1'b1;
                // run/step_mode only take effect once the pending instruction is accepted
                if (ir_ready) begin
                    if (halt_hit) begin
                        state_next = S_HALT;
                    end else if (step_mode) begin
                        state_next = S_PAUSE;
                    end else if (!run) begin
                        state_next = S_IDLE;
                    end else begin
                        state_next = S_FETCH;
                    end
                end
            end
            S_PAUSE: begin
                if (!run) begin
                    state_next = S_IDLE;
                end else if (step || !step_mode) begin
                    state_next = S_FETCH;
                end
            end
            S_HALT: begin
                state_next = S_HALT;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= S_IDLE;
            pc_reg          <= '0;
            pc_next_reg     <= '0;
            ir_reg          <= '0;
            halted_reg      <= 1'b0;
            instr_count_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == S_FETCH) begin
                ir_reg <= rom_data;
                pc_reg <= pc_next_reg;
            end
            if (handshake) begin
                pc_next_reg <= resolved_pc;
                if (instr_count_reg != {CNT_W{1'b1}}) begin
                    instr_count_reg <= instr_count_reg + CNT_W'(1);
                end
                if (halt_hit) begin
                    halted_reg <= 1'b1;
                end
            end
        end
    end

    assign rom_addr    = pc_next_reg;
    assign ir          = ir_reg;
    assign pc          = pc_reg;
    assign halted      = halted_reg;
    assign instr_count = instr_count_reg;

endmodule

// File: tb/tb_k2_fetch_sequencer.sv
// Scoreboard bench for k2_fetch_sequencer: stimulus pushes expected issues,
// a negedge monitor pops and compares on every handshake.
module tb_k2_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst, run, step_mode, step, ir_ready, carry_in;
    logic [3:0]  rom_addr, pc, s_rom_addr, s_pc;
    logic [7:0]  rom_data, ir, s_rom_data, s_ir;
    logic        ir_valid, halted, s_ir_valid, s_halted;
    logic [15:0] instr_count;
    logic [2:0]  s_count;
    logic [7:0]  rom [16];

    typedef struct packed {
        logic [3:0] pc;
        logic [7:0] ir;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          n_checks = 0;
    int          n_pass = 0;
    int          hs_count = 0;
    int          cyc = 0;
    int          last_hs_cyc = 0;
    logic [15:0] exp_cnt = 16'd0;
    logic [2:0]  exp_sat = 3'd0;

    always #5 clk = ~clk;

    assign rom_data   = rom[rom_addr];
    assign s_rom_data = rom[s_rom_addr];

    k2_fetch_sequencer dut (
        .clk(clk), .rst(rst), .run(run), .step_mode(step_mode), .step(step),
        .rom_addr(rom_addr), .rom_data(rom_data), .ir(ir), .ir_valid(ir_valid),
        .ir_ready(ir_ready), .carry_in(carry_in), .pc(pc), .halted(halted),
        .instr_count(instr_count)
    );

    // Narrow-counter twin in lockstep, so saturation is reached in a short run.
    k2_fetch_sequencer #(.CNT_W(3)) dut_sat (
        .clk(clk), .rst(rst), .run(run), .step_mode(step_mode), .step(step),
        .rom_addr(s_rom_addr), .rom_data(s_rom_data), .ir(s_ir), .ir_valid(s_ir_valid),
        .ir_ready(ir_ready), .carry_in(carry_in), .pc(s_pc), .halted(s_halted),
        .instr_count(s_count)
    );

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst) begin
            exp_cnt <= 16'd0;
            exp_sat <= 3'd0;
        end else if (ir_valid && ir_ready) begin
            hs_count    <= hs_count + 1;
            last_hs_cyc <= cyc;
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_hs: got issue pc=%0d ir=0x%0h, expected none", pc, ir);
            end else begin
                mon_e = exp_q.pop_front();
                $display("issue pc=%0d ir=0x%02h count=%0d", pc, ir, instr_count);
                check("hs_pc", 32'(pc), 32'(mon_e.pc));
                check("hs_ir", 32'(ir), 32'(mon_e.ir));
                check("hs_count", 32'(instr_count), 32'(exp_cnt));
                check("hs_sat_pc", 32'(s_pc), 32'(mon_e.pc));
                check("hs_sat_count", 32'(s_count), 32'(exp_sat));
            end
            if (exp_cnt != 16'hFFFF) exp_cnt <= exp_cnt + 16'd1;
            if (exp_sat != 3'd7) exp_sat <= exp_sat + 3'd1;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input int p);
        exp_t e;
        e.pc = 4'(p);
        e.ir = rom[p];
        exp_q.push_back(e);
    endtask

    task automatic wait_hs(input int target, input string name);
        for (int k = 0; k < 400 && hs_count < target; k++) tick(1);
        check(name, 32'(hs_count), 32'(target));
    endtask

    // From IDLE: issue n instructions (already pushed) and return to IDLE.
    task automatic run_seq(input int n, input int first_pc, input string name);
        int base;
        int c0;
        base = hs_count;
        run = 1'b1;
        c0 = cyc;
        tick(1);
        check({name, "_fetch_nv"}, 32'(ir_valid), 32'd0);
        tick(1);
        check({name, "_first_valid"}, 32'(ir_valid), 32'd1);
        check({name, "_first_pc"}, 32'(pc), 32'(first_pc));
        wait_hs(base + n - 1, {name, "_hs"});
        run = 1'b0;
        wait_hs(base + n, {name, "_last_hs"});
        check({name, "_cadence"}, 32'(last_hs_cyc - c0), 32'(2 * n));
        tick(3);
        check({name, "_idle"}, 32'(ir_valid), 32'd0);
    endtask

    initial begin
        int base;
        for (int i = 0; i < 16; i++) rom[i] = 8'h10 + 8'(i);
        rst = 1'b1; run = 1'b0; step_mode = 1'b0; step = 1'b0;
        ir_ready = 1'b1; carry_in = 1'b0;

        // Reset values
        tick(2);
        rst = 1'b0;
        check("rst_ir_valid", 32'(ir_valid), 32'd0);
        check("rst_pc", 32'(pc), 32'd0);
        check("rst_rom_addr", 32'(rom_addr), 32'd0);
        check("rst_ir", 32'(ir), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_count", 32'(instr_count), 32'd0);

        // Straight-line run with wrap 15->0
        for (int i = 0; i < 16; i++) push(i);
        push(0); push(1);
        run_seq(18, 0, "seq");
        check("seq_count", 32'(instr_count), 32'd18);
        check("seq_sat_count", 32'(s_count), 32'd7);

        // Backpressure, then run dropped while the instruction is pending
        ir_ready = 1'b0;
        push(2);
        base = hs_count;
        run = 1'b1;
        tick(2);
        check("bp_valid", 32'(ir_valid), 32'd1);
        tick(5);
        check("bp_ir_hold", 32'(ir), 32'h12);
        check("bp_pc_hold", 32'(pc), 32'd2);
        check("bp_no_fetch", 32'(rom_addr), 32'd2);
        check("bp_count_hold", 32'(instr_count), 32'd18);
        run = 1'b0;
        tick(1);
        check("rundrop_valid", 32'(ir_valid), 32'd1);
        ir_ready = 1'b1;
        wait_hs(base + 1, "rundrop_hs");
        tick(3);
        check("rundrop_idle", 32'(ir_valid), 32'd0);

        // JC at 9 not taken
        rom[9] = 8'hB6;
        for (int i = 3; i <= 10; i++) push(i);
        run_seq(8, 3, "jc_nt");

        // J at 5 -> 3
        rom[5] = 8'hA3;
        for (int i = 11; i < 16; i++) push(i);
        for (int i = 0; i <= 5; i++) push(i);
        push(3); push(4);
        run_seq(13, 11, "j");

        // JC at 9 taken -> 6
        rom[5] = 8'h15;
        carry_in = 1'b1;
        for (int i = 5; i <= 9; i++) push(i);
        push(6); push(7);
        run_seq(7, 5, "jc_t");
        carry_in = 1'b0;

        // Step mode
        step_mode = 1'b1;
        base = hs_count;
        push(8);
        run = 1'b1;
        wait_hs(base + 1, "step_first");
        tick(5);
        check("step_paused", 32'(hs_count), 32'(base + 1));
        check("step_paused_nv", 32'(ir_valid), 32'd0);
        ir_ready = 1'b0;
        push(9);
        step = 1'b1; tick(1); step = 1'b0;
        tick(1);
        check("step_issue_pc", 32'(pc), 32'd9);
        step = 1'b1; tick(1); step = 1'b0;
        ir_ready = 1'b1;
        wait_hs(base + 2, "step_second");
        tick(5);
        check("step_outside_ignored", 32'(hs_count), 32'(base + 2));
        push(10);
        step = 1'b1; tick(1); step = 1'b0;
        wait_hs(base + 3, "step_third");
        tick(5);
        check("step_one_each", 32'(hs_count), 32'(base + 3));
        push(11); push(12);
        step_mode = 1'b0;
        wait_hs(base + 4, "step_resume");
        run = 1'b0;
        wait_hs(base + 5, "step_resume_last");
        tick(3);
        check("step_idle", 32'(ir_valid), 32'd0);

        // Self-jump halt at 4
        rom[4] = 8'hA4;
        for (int i = 13; i < 16; i++) push(i);
        for (int i = 0; i <= 4; i++) push(i);
        base = hs_count;
        run = 1'b1;
        wait_hs(base + 8, "halt_hs");
        tick(6);
        check("halt_flag", 32'(halted), 32'd1);
        check("halt_no_valid", 32'(ir_valid), 32'd0);
        check("halt_no_issue", 32'(hs_count), 32'(base + 8));
        check("halt_sat_flag", 32'(s_halted), 32'd1);
        check("halt_sat_no_valid", 32'(s_ir_valid), 32'd0);
        run = 1'b0;
        rst = 1'b1; tick(1); rst = 1'b0;
        check("halt_rst_flag", 32'(halted), 32'd0);
        check("halt_rst_pc", 32'(pc), 32'd0);
        check("halt_rst_count", 32'(instr_count), 32'd0);

        // Reset while an instruction is pending in ISSUE
        rom[4] = 8'h14;
        push(0); push(1); push(2);
        run_seq(3, 0, "pre_rst");
        ir_ready = 1'b0;
        run = 1'b1;
        tick(2);
        check("mid_valid", 32'(ir_valid), 32'd1);
        check("mid_pc", 32'(pc), 32'd3);
        rst = 1'b1; run = 1'b0;
        tick(1);
        check("mid_rst_valid", 32'(ir_valid), 32'd0);
        check("mid_rst_ir", 32'(ir), 32'd0);
        check("mid_rst_pc", 32'(pc), 32'd0);
        check("mid_rst_rom_addr", 32'(rom_addr), 32'd0);
        check("mid_rst_count", 32'(instr_count), 32'd0);
        check("mid_rst_sat_valid", 32'(s_ir_valid), 32'd0);
        rst = 1'b0;
        ir_ready = 1'b1;
        tick(3);
        check("mid_rst_idle", 32'(ir_valid), 32'd0);
        check("mid_rst_sat_ir", 32'(s_ir), 32'd0);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
